// File: rtl/pc_unit_ras_if.sv
// Fetch-side bundle for pc_unit_ras: control requests, operands and PC/RAS status.
interface pc_unit_ras_if #(
  parameter int INSTR_ADDR_WIDTH = 32,
  parameter int RAS_DEPTH        = 8
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic                        clk_en;
  logic                        stall;
  logic [3:0]                  flags;
  logic                        branch_en;
  logic [3:0]                  branch_cond;
  logic                        jump_en;
  logic                        link_en;
  logic                        ret_en;
  logic                        instr_len;
  logic [INSTR_ADDR_WIDTH-1:0] branch_base_addr;
  logic [INSTR_ADDR_WIDTH-1:0] short_offset;
  logic [INSTR_ADDR_WIDTH-1:0] long_offset;
  logic [INSTR_ADDR_WIDTH-1:0] pc;
  logic [INSTR_ADDR_WIDTH-1:0] next_instr_addr;
  logic [INSTR_ADDR_WIDTH-1:0] link_addr;
  logic                        redirect;
  logic [CW-1:0]               ras_count;
  logic                        ras_overflow;
  logic                        ras_underflow;

  modport master (
    output clk_en, stall, flags, branch_en, branch_cond, jump_en, link_en, ret_en,
           instr_len, branch_base_addr, short_offset, long_offset,
    input  pc, next_instr_addr, link_addr, redirect, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  clk_en, stall, flags, branch_en, branch_cond, jump_en, link_en, ret_en,
           instr_len, branch_base_addr, short_offset, long_offset,
    output pc, next_instr_addr, link_addr, redirect, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_unit_ras.sv
// Fetch PC generator: sequential / conditional branch / jump / return select,
// with a circular return-address stack that overwrites its oldest entry when full.
module pc_unit_ras #(
  parameter int                          INSTR_ADDR_WIDTH = 32,
  parameter int                          RAS_DEPTH        = 8,
  parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_VECTOR     = '0,
  parameter int                          OFFSET_SHIFT     = 1
) (
  input logic          clk,
  input logic          sync_rst,
  pc_unit_ras_if.slave bus
);
  localparam int AW = INSTR_ADDR_WIDTH;
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {SRC_HOLD, SRC_RET, SRC_BR, SRC_JMP, SRC_SEQ} src_e;

  logic [AW-1:0] pc_q, seq, br_tgt, jmp_tgt, nxt, ras_top;
  logic [AW-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] sp;
  logic [CW-1:0] cnt;
  logic          redir_q, ovf_q, unf_q;
  logic          cond_ok, ras_empty, ras_full, push;
  src_e          src;

  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0:    return 1'b1;
      4'd1:    return z;
      4'd2:    return !z;
      4'd3:    return c;
      4'd4:    return !c;
      4'd5:    return n;
      4'd6:    return !n;
      4'd7:    return v;
      4'd8:    return !v;
      4'd9:    return c && !z;
      4'd10:   return !c || z;
      4'd11:   return n == v;
      4'd12:   return n != v;
      4'd13:   return !z && (n == v);
      4'd14:   return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  assign seq       = pc_q + (bus.instr_len ? AW'(4) : AW'(2));
  assign br_tgt    = bus.branch_base_addr + (bus.short_offset << OFFSET_SHIFT);
  assign jmp_tgt   = pc_q + (bus.long_offset << OFFSET_SHIFT);
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == CW'(RAS_DEPTH));
  assign ras_top   = ras[sp - PW'(1)];
  assign cond_ok   = cond_eval(bus.branch_cond, bus.flags);

  always_comb begin
    src = SRC_SEQ;
    nxt = seq;
    if (bus.stall) begin
      src = SRC_HOLD;
      nxt = pc_q;
    end else if (bus.ret_en && !ras_empty) begin
      src = SRC_RET;
      nxt = ras_top;
    end else if (bus.branch_en && cond_ok) begin
      src = SRC_BR;
      nxt = br_tgt;
    end else if (bus.jump_en) begin
      src = SRC_JMP;
      nxt = jmp_tgt;
    end
  end

  assign push = bus.link_en && (src == SRC_BR || src == SRC_JMP);

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      pc_q    <= RESET_VECTOR;
      redir_q <= 1'b0;
      sp      <= '0;
      cnt     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (bus.clk_en) begin
      pc_q    <= nxt;
      redir_q <= (src == SRC_RET) || (src == SRC_BR) || (src == SRC_JMP);
      // Full push keeps the count and lets sp wrap over the oldest slot.
      if (push) begin
        sp <= sp + PW'(1);
        if (ras_full) ovf_q <= 1'b1;
        else          cnt   <= cnt + CW'(1);
      end else if (src == SRC_RET) begin
        sp  <= sp - PW'(1);
        cnt <= cnt - CW'(1);
      end
      if (!bus.stall && bus.ret_en && ras_empty) unf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst && bus.clk_en && push) ras[sp] <= seq;
  end

  assign bus.pc              = pc_q;
  assign bus.next_instr_addr = nxt;
  assign bus.link_addr       = seq;
  assign bus.redirect        = redir_q;
  assign bus.ras_count       = cnt;
  assign bus.ras_overflow    = ovf_q;
  assign bus.ras_underflow   = unf_q;
endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed and randomized checks of pc_unit_ras against a queue-based reference model.
module tb_pc_unit_ras;
  localparam logic [31:0] RV = 32'h100;

  logic clk, rst;
  int   checks, failures;

  pc_unit_ras_if #(.INSTR_ADDR_WIDTH(32), .RAS_DEPTH(8)) b();
  pc_unit_ras #(.INSTR_ADDR_WIDTH(32), .RAS_DEPTH(8), .RESET_VECTOR(RV), .OFFSET_SHIFT(1))
    dut (.clk(clk), .sync_rst(rst), .bus(b));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // reference model state
  logic [31:0] m_pc;
  logic        m_redir, m_ovf, m_unf;
  logic [31:0] m_ras[$];

  function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      0: return 1;        1: return z;         2: return !z;        3: return cf;
      4: return !cf;      5: return n;         6: return !n;        7: return v;
      8: return !v;       9: return cf && !z;  10: return !cf || z; 11: return n == v;
      12: return n != v;  13: return !z && n == v; 14: return z || n != v;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_seq();
    return m_pc + (b.instr_len ? 32'd4 : 32'd2);
  endfunction

  function automatic logic [31:0] m_next();
    if (b.stall) return m_pc;
    if (b.ret_en && m_ras.size() > 0) return m_ras[$];
    if (b.branch_en && m_cond(b.branch_cond, b.flags)) return b.branch_base_addr + (b.short_offset << 1);
    if (b.jump_en) return m_pc + (b.long_offset << 1);
    return m_seq();
  endfunction

  task automatic m_clock();
    logic [31:0] nx, s;
    logic        red, lnk;
    if (rst) begin
      m_pc = RV; m_redir = 0; m_ovf = 0; m_unf = 0; m_ras.delete();
    end else if (b.clk_en) begin
      s = m_seq(); nx = s; red = 0; lnk = 0;
      if (b.stall) nx = m_pc;
      else if (b.ret_en && m_ras.size() > 0) begin nx = m_ras.pop_back(); red = 1; end
      else begin
        if (b.ret_en) m_unf = 1;
        if (b.branch_en && m_cond(b.branch_cond, b.flags)) begin
          nx = b.branch_base_addr + (b.short_offset << 1); red = 1; lnk = b.link_en;
        end else if (b.jump_en) begin
          nx = m_pc + (b.long_offset << 1); red = 1; lnk = b.link_en;
        end
      end
      if (lnk) begin
        m_ras.push_back(s);
        if (m_ras.size() > 8) begin void'(m_ras.pop_front()); m_ovf = 1; end
      end
      m_pc = nx; m_redir = red;
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    b.clk_en = 1; b.stall = 0; b.flags = 0; b.branch_en = 0; b.branch_cond = 0;
    b.jump_en = 0; b.link_en = 0; b.ret_en = 0; b.instr_len = 0;
    b.branch_base_addr = 0; b.short_offset = 0; b.long_offset = 0;
  endtask

  task automatic set_pc(input logic [31:0] a);
    idle(); b.branch_en = 1; b.branch_cond = 0; b.branch_base_addr = a; cyc(); idle();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h100; exp_pc[1] = 32'h102; exp_pc[2] = 32'h106; exp_pc[3] = 32'h108;
    idle(); b.clk_en = 0; b.jump_en = 1; b.long_offset = 32'h40; rst = 1; cyc(); rst = 0;
    checks++; if (b.pc !== RV) begin failures++; $display("FAIL reset_pc got=%h exp=%h", b.pc, RV); end
    checks++; if (b.redirect !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%b exp=0", b.redirect); end
    checks++; if (b.ras_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", b.ras_count); end
    checks++; if ({b.ras_overflow, b.ras_underflow} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {b.ras_overflow, b.ras_underflow}); end
    for (int i = 1; i < 4; i++) begin
      idle(); b.instr_len = (i == 2);
      #1;
      checks++; if (b.link_addr !== exp_pc[i]) begin failures++; $display("FAIL seq_link got=%h exp=%h", b.link_addr, exp_pc[i]); end
      cyc();
      checks++; if (b.pc !== exp_pc[i]) begin failures++; $display("FAIL seq_pc got=%h exp=%h", b.pc, exp_pc[i]); end
      checks++; if (b.redirect !== 1'b0) begin failures++; $display("FAIL seq_redirect got=%b exp=0", b.redirect); end
    end
  endtask

  task automatic test_branch();
    set_pc(32'h200);
    b.flags = 4'b0100; b.branch_en = 1; b.branch_cond = 1;
    b.branch_base_addr = 32'h1000; b.short_offset = 32'hFFFF_FFFE;
    #1;
    checks++; if (b.next_instr_addr !== 32'h0FFC) begin failures++; $display("FAIL br_next got=%h exp=00000ffc", b.next_instr_addr); end
    cyc();
    checks++; if (b.pc !== 32'h0FFC) begin failures++; $display("FAIL br_pc got=%h exp=00000ffc", b.pc); end
    checks++; if (b.redirect !== 1'b1) begin failures++; $display("FAIL br_redirect got=%b exp=1", b.redirect); end
    idle(); cyc();
    checks++; if (b.redirect !== 1'b0) begin failures++; $display("FAIL br_pulse got=%b exp=0", b.redirect); end
    set_pc(32'h200);
    b.flags = 4'b0000; b.branch_en = 1; b.branch_cond = 1;
    b.branch_base_addr = 32'h1000; b.short_offset = 32'hFFFF_FFFE;
    cyc();
    checks++; if (b.pc !== 32'h202) begin failures++; $display("FAIL br_nt_pc got=%h exp=00000202", b.pc); end
    checks++; if (b.redirect !== 1'b0) begin failures++; $display("FAIL br_nt_redirect got=%b exp=0", b.redirect); end
  endtask

  task automatic test_jump_ret();
    set_pc(32'h300);
    b.jump_en = 1; b.link_en = 1; b.long_offset = 32'h10; b.instr_len = 1;
    cyc();
    checks++; if (b.pc !== 32'h320) begin failures++; $display("FAIL jmp_pc got=%h exp=00000320", b.pc); end
    checks++; if (b.ras_count !== 4'd1) begin failures++; $display("FAIL jmp_count got=%0d exp=1", b.ras_count); end
    idle(); b.ret_en = 1; cyc();
    checks++; if (b.pc !== 32'h304) begin failures++; $display("FAIL ret_pc got=%h exp=00000304", b.pc); end
    checks++; if (b.ras_count !== 4'd0) begin failures++; $display("FAIL ret_count got=%0d exp=0", b.ras_count); end
    checks++; if (b.redirect !== 1'b1) begin failures++; $display("FAIL ret_redirect got=%b exp=1", b.redirect); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] a [10];
    logic [31:0] cur;
    set_pc(32'h4000); cur = 32'h4000;
    for (int i = 1; i <= 9; i++) begin
      idle(); b.branch_en = 1; b.link_en = 1; b.branch_base_addr = 32'h10000 * i;
      a[i] = cur + 2; cur = b.branch_base_addr;
      cyc();
      if (i == 8) begin
        checks++; if ({b.ras_count, b.ras_overflow} !== {4'd8, 1'b0}) begin failures++; $display("FAIL full8 got=%0d/%b exp=8/0", b.ras_count, b.ras_overflow); end
      end
    end
    checks++; if (b.ras_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", b.ras_count); end
    checks++; if (b.ras_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", b.ras_overflow); end
    for (int k = 1; k <= 8; k++) begin
      idle(); b.ret_en = 1; cyc();
      checks++; if (b.pc !== a[10-k]) begin failures++; $display("FAIL lifo_pc k=%0d got=%h exp=%h", k, b.pc, a[10-k]); end
      cur = a[10-k];
    end
    idle(); b.ret_en = 1; cyc();
    checks++; if (b.pc !== cur + 32'd2) begin failures++; $display("FAIL unf_pc got=%h exp=%h", b.pc, cur + 32'd2); end
    checks++; if (b.ras_underflow !== 1'b1) begin failures++; $display("FAIL unf_flag got=%b exp=1", b.ras_underflow); end
    checks++; if (b.redirect !== 1'b0) begin failures++; $display("FAIL unf_redirect got=%b exp=0", b.redirect); end
    checks++; if (b.ras_count !== 4'd0) begin failures++; $display("FAIL unf_count got=%0d exp=0", b.ras_count); end
  endtask

  task automatic test_stall_clk_en();
    set_pc(32'h500);
    b.stall = 1; b.jump_en = 1; b.link_en = 1; b.long_offset = 32'h40;
    #1;
    checks++; if (b.next_instr_addr !== 32'h500) begin failures++; $display("FAIL stall_next got=%h exp=00000500", b.next_instr_addr); end
    cyc();
    checks++; if (b.pc !== 32'h500) begin failures++; $display("FAIL stall_pc got=%h exp=00000500", b.pc); end
    checks++; if (b.ras_count !== 4'd0) begin failures++; $display("FAIL stall_count got=%0d exp=0", b.ras_count); end
    checks++; if (b.redirect !== 1'b0) begin failures++; $display("FAIL stall_redirect got=%b exp=0", b.redirect); end
    set_pc(32'h600);
    b.clk_en = 0; b.jump_en = 1; b.link_en = 1; b.long_offset = 32'h40;
    cyc(); cyc();
    checks++; if (b.pc !== 32'h600) begin failures++; $display("FAIL ce_pc got=%h exp=00000600", b.pc); end
    checks++; if (b.redirect !== 1'b1) begin failures++; $display("FAIL ce_redirect_hold got=%b exp=1", b.redirect); end
    checks++; if (b.ras_count !== 4'd0) begin failures++; $display("FAIL ce_count got=%0d exp=0", b.ras_count); end
  endtask

  task automatic test_cond_sweep();
    logic [31:0] exp;
    set_pc(32'h800);
    b.clk_en = 0; b.branch_en = 1; b.branch_base_addr = 32'hA000;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        b.branch_cond = 4'(c); b.flags = 4'(f);
        #1;
        exp = m_cond(4'(c), 4'(f)) ? 32'hA000 : 32'h802;
        checks++; if (b.next_instr_addr !== exp) begin failures++; $display("FAIL cond c=%0d f=%h got=%h exp=%h", c, f, b.next_instr_addr, exp); end
      end
    end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] exp;
    idle(); rst = 1; m_clock(); cyc(); rst = 0;
    for (int n = 0; n < 500; n++) begin
      idle();
      rst = ($urandom_range(0, 60) == 0);
      b.clk_en = ($urandom_range(0, 9) != 0);
      b.stall = ($urandom_range(0, 7) == 0);
      b.flags = 4'($urandom()); b.branch_cond = 4'($urandom());
      b.instr_len = 1'($urandom());
      b.link_en = 1'($urandom());
      b.branch_base_addr = $urandom();
      b.short_offset = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($signed(8'($urandom())));
      b.long_offset = $urandom();
      b.ret_en = ($urandom_range(0, 3) == 0);
      if (!b.ret_en) begin
        b.branch_en = 1'($urandom()); b.jump_en = ($urandom_range(0, 2) == 0);
      end
      #1;
      exp = m_next();
      checks++; if (b.next_instr_addr !== exp) begin failures++; $display("FAIL rnd_next n=%0d got=%h exp=%h", n, b.next_instr_addr, exp); end
      m_clock();
      cyc();
      checks++; if (b.pc !== m_pc) begin failures++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, b.pc, m_pc); end
      checks++; if (b.redirect !== m_redir) begin failures++; $display("FAIL rnd_redirect n=%0d got=%b exp=%b", n, b.redirect, m_redir); end
      checks++; if (b.ras_count !== 4'(m_ras.size())) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, b.ras_count, m_ras.size()); end
      checks++; if ({b.ras_overflow, b.ras_underflow} !== {m_ovf, m_unf}) begin failures++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, {b.ras_overflow, b.ras_underflow}, {m_ovf, m_unf}); end
    end
    rst = 0;
  endtask

  initial begin
    checks = 0; failures = 0; rst = 0;
    idle();
    test_reset();
    test_branch();
    test_jump_ret();
    test_ras_overflow();
    test_stall_clk_en();
    test_cond_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
